// File: rtl/calc_pkg.sv
// Shared definitions for the calculator program loader.
// Holds the loader FSM state encoding, the default memory geometry and
// the two standard fetch-hold lengths used by the core variants.
package calc_pkg;

  localparam int DEF_ADDRESS_WIDTH = 10;
  localparam int DEF_DATA_WIDTH    = 18;

  // Hold lengths for the pipelined and the sequential calculator core
  localparam int STEP_PIPE = 1;
  localparam int STEP_SEQ  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/calc_step_timer.sv
// Fetch-address hold counter: counts 0..STEP_CYCLES-1 while enabled and
// flags the terminal count with tick. clr forces the count back to zero.
module calc_step_timer
  import calc_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_PIPE
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [3:0] LAST_COUNT = 4'(STEP_CYCLES - 1);

  logic [3:0] r_count;

  assign tick = en && (r_count == LAST_COUNT);

  // Hold count, restarting after every terminal count
  always_ff @(posedge CLK) begin
    if (!RST_N || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= tick ? 4'd0 : r_count + 4'd1;
    end
  end

endmodule

// File: rtl/calc_program_loader.sv
// Program loader for the calculator core: streams instruction words into
// the instruction memory, then walks the fetch address across the loaded
// program holding each address STEP_CYCLES cycles.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running sum output.
module calc_program_loader
  import calc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int STEP_CYCLES   = STEP_PIPE
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     start,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [ADDRESS_WIDTH-1:0] Counter,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   prog_len,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]    checksum,
`endif
  output logic                     overflow
);

  localparam logic [ADDRESS_WIDTH:0] CAPACITY = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  state_t r_state, w_nextState;

  logic [ADDRESS_WIDTH:0]   r_wptr, r_progLen, w_curPtr, w_ptrNext;
  logic [ADDRESS_WIDTH-1:0] r_waddr, r_counter;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic r_full, r_ovf, r_we;
  logic w_ready, w_accept, w_endLoad, w_runEn, w_tick, w_lastAddr, w_busy, w_done;

  // r_full blocks the stream after the memory filled up without in_last,
  // until the writer drops in_valid; otherwise extra words would start a new load.
  assign w_ready    = RST_N && (((r_state == IDLE) && !r_full) || (r_state == LOAD));
  assign w_accept   = in_valid && w_ready;
  assign w_curPtr   = (r_state == IDLE) ? '0 : r_wptr;
  assign w_ptrNext  = w_curPtr + 1'b1;
  assign w_endLoad  = w_accept && (in_last || (w_ptrNext == CAPACITY));
  assign w_runEn    = (r_state == RUN);
  assign w_lastAddr = ({1'b0, r_counter} == (r_progLen - 1'b1));

  calc_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_stepTimer (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (w_runEn),
    .clr  (!w_runEn),
    .tick (w_tick)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; a load beats a simultaneous start in IDLE
  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_endLoad) w_nextState = LOAD;
        end else if (start && (r_progLen != '0)) begin
          w_nextState = RUN;
        end
      end
      LOAD: begin
        w_busy = 1'b1;
        if (w_endLoad) w_nextState = IDLE;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_tick && w_lastAddr) w_nextState = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Write port, write pointer, program length and capacity flags
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wptr    <= '0;
      r_progLen <= '0;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_waddr <= w_curPtr[ADDRESS_WIDTH-1:0];
        r_wdata <= in_data;
        r_wptr  <= w_ptrNext;
      end
      if (w_endLoad) r_progLen <= w_ptrNext;
      if ((r_state == IDLE) && !in_valid) r_full <= 1'b0;
      if (w_endLoad && !in_last) r_full <= 1'b1;
      if ((r_state == IDLE) && r_full && in_valid) r_ovf <= 1'b1;
    end
  end

  // Fetch address: zeroed on run entry, advanced on each hold terminal count
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_counter <= '0;
    end else if ((r_state == IDLE) && (w_nextState == RUN)) begin
      r_counter <= '0;
    end else if (w_runEn && w_tick && !w_lastAddr) begin
      r_counter <= r_counter + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Wrapping sum of the current load, restarted by its first word
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= (r_state == IDLE) ? in_data : r_checksum + in_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign in_ready  = w_ready;
  assign mem_we    = r_we;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign Counter   = r_counter;
  assign busy      = w_busy;
  assign done      = w_done;
  assign prog_len  = r_progLen;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_calc_program_loader.sv
// Testbench for calc_program_loader: instance A (10-bit address, 3-cycle
// hold) and instance B (2-bit address, 1-cycle hold) against a queue-based
// reference of the load/run behaviour. Honors LOADER_CHECKSUM_EN.
module tb_calc_program_loader;
  import calc_pkg::*;

  localparam int AWA = 10;
  localparam int AWB = 2;
  localparam int DW  = 18;

  logic clk = 1'b0;
  logic rstn;

  logic aValid, aLast, aStart, aReady, aWe, aBusy, aDone, aOvf;
  logic [DW-1:0]  aData, aWdata;
  logic [AWA-1:0] aWaddr, aCounter;
  logic [AWA:0]   aLen;

  logic bValid, bLast, bStart, bReady, bWe, bBusy, bDone, bOvf;
  logic [DW-1:0]  bData, bWdata;
  logic [AWB-1:0] bWaddr, bCounter;
  logic [AWB:0]   bLen;

`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] aChecksum, bChecksum;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] words[$];

  // Free-running clock
  always #5 clk = ~clk;

  calc_program_loader #(.ADDRESS_WIDTH(AWA), .DATA_WIDTH(DW), .STEP_CYCLES(STEP_SEQ)) dutA (
    .CLK(clk), .RST_N(rstn), .in_valid(aValid), .in_data(aData), .in_last(aLast),
    .in_ready(aReady), .start(aStart), .mem_we(aWe), .mem_waddr(aWaddr),
    .mem_wdata(aWdata), .Counter(aCounter), .busy(aBusy), .done(aDone),
    .prog_len(aLen),
`ifdef LOADER_CHECKSUM_EN
    .checksum(aChecksum),
`endif
    .overflow(aOvf)
  );

  calc_program_loader #(.ADDRESS_WIDTH(AWB), .DATA_WIDTH(DW), .STEP_CYCLES(STEP_PIPE)) dutB (
    .CLK(clk), .RST_N(rstn), .in_valid(bValid), .in_data(bData), .in_last(bLast),
    .in_ready(bReady), .start(bStart), .mem_we(bWe), .mem_waddr(bWaddr),
    .mem_wdata(bWdata), .Counter(bCounter), .busy(bBusy), .done(bDone),
    .prog_len(bLen),
`ifdef LOADER_CHECKSUM_EN
    .checksum(bChecksum),
`endif
    .overflow(bOvf)
  );

  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    aValid = 0; aLast = 0; aStart = 0; aData = '0;
    bValid = 0; bLast = 0; bStart = 0; bData = '0;
    stepClock();
    stepClock();
    checks++;
    if ({aReady, aWe, aBusy, aDone, aOvf, aWaddr, aWdata, aCounter, aLen} !== '0)
      begin errors++; $display("[TB] FAIL resetA: outputs=%h required all zero",
        {aReady, aWe, aBusy, aDone, aOvf, aWaddr, aWdata, aCounter, aLen}); end
    checks++;
    if ({bReady, bWe, bBusy, bDone, bOvf, bWaddr, bWdata, bCounter, bLen} !== '0)
      begin errors++; $display("[TB] FAIL resetB: outputs=%h required all zero",
        {bReady, bWe, bBusy, bDone, bOvf, bWaddr, bWdata, bCounter, bLen}); end
    rstn = 1'b1;
    stepClock();
    checks++;
    if (aReady !== 1'b1 || aBusy !== 1'b0 || bReady !== 1'b1)
      begin errors++; $display("[TB] FAIL idleAfterReset: readyA=%b busyA=%b readyB=%b required 1 0 1",
        aReady, aBusy, bReady); end
  endtask

  // Load the words queue into A, with random idle gaps between words
  task automatic loadA(input string name);
    logic [DW-1:0] sum;
    int n;
    int gaps;
    sum = '0;
    n = words.size();
    for (int i = 0; i < n; i++) begin
      gaps = $urandom_range(0, 2);
      repeat (gaps) begin
        aValid = 0; aLast = 0;
        stepClock();
        checks++;
        if (aWe !== 1'b0) begin errors++; $display("[TB] FAIL %s gapWe: got %b required 0", name, aWe); end
      end
      aValid = 1; aData = words[i]; aLast = (i == n - 1);
      checks++;
      if (aReady !== 1'b1) begin errors++; $display("[TB] FAIL %s ready word %0d: got %b required 1", name, i, aReady); end
      stepClock();
      checks++;
      if (aWe !== 1'b1 || aWaddr !== AWA'(i) || aWdata !== words[i]) begin
        errors++;
        $display("[TB] FAIL %s write %0d: we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
          name, i, aWe, aWaddr, aWdata, i, words[i]);
      end
      checks++;
      if (aBusy !== (i != n - 1)) begin errors++; $display("[TB] FAIL %s busy word %0d: got %b required %b", name, i, aBusy, (i != n - 1)); end
      sum = sum + words[i];
    end
    aValid = 0; aLast = 0;
    checks++;
    if (aLen !== (AWA + 1)'(n)) begin errors++; $display("[TB] FAIL %s progLen: got %0d required %0d", name, aLen, n); end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (aChecksum !== sum) begin errors++; $display("[TB] FAIL %s checksum: got %h required %h", name, aChecksum, sum); end
`endif
  endtask

  // Run A's program; each address held 3 cycles, stray start mid-run is ignored
  task automatic runA(input int len);
    aStart = 1;
    stepClock();
    aStart = 0;
    for (int t = 0; t < len * 3; t++) begin
      checks++;
      if (aCounter !== AWA'(t / 3) || aBusy !== 1'b1 || aDone !== 1'b0 || aReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL runA t=%0d: counter=%0d busy=%b done=%b ready=%b required %0d 1 0 0",
          t, aCounter, aBusy, aDone, aReady, t / 3);
      end
      aStart = (t == 2);
      stepClock();
    end
    aStart = 0;
    checks++;
    if (aDone !== 1'b1 || aBusy !== 1'b0 || aCounter !== AWA'(len - 1)) begin
      errors++;
      $display("[TB] FAIL runA donePulse: done=%b busy=%b counter=%0d required 1 0 %0d", aDone, aBusy, aCounter, len - 1);
    end
    stepClock();
    checks++;
    if (aDone !== 1'b0 || aBusy !== 1'b0 || aCounter !== AWA'(len - 1) || aReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL runA afterDone: done=%b busy=%b counter=%0d ready=%b required 0 0 %0d 1",
        aDone, aBusy, aCounter, aReady, len - 1);
    end
  endtask

  task automatic test_start_empty();
    logic [DW-1:0] w;
    bStart = 1;
    stepClock();
    bStart = 0;
    checks++;
    if (bBusy !== 1'b0 || bDone !== 1'b0 || bCounter !== '0)
      begin errors++; $display("[TB] FAIL emptyStart: busy=%b done=%b counter=%0d required 0 0 0", bBusy, bDone, bCounter); end
    stepClock();
    checks++;
    if (bBusy !== 1'b0 || bDone !== 1'b0)
      begin errors++; $display("[TB] FAIL emptyStartLater: busy=%b done=%b required 0 0", bBusy, bDone); end
    w = DW'($urandom);
    bValid = 1; bData = w; bLast = 1;
    stepClock();
    bValid = 0; bLast = 0;
    checks++;
    if (bWe !== 1'b1 || bWaddr !== '0 || bWdata !== w || bLen !== 3'd1 || bBusy !== 1'b0)
      begin errors++; $display("[TB] FAIL singleLoad: we=%b addr=%0d data=%h len=%0d busy=%b required 1 0 %h 1 0",
        bWe, bWaddr, bWdata, bLen, bBusy, w); end
    bStart = 1;
    stepClock();
    bStart = 0;
    checks++;
    if (bBusy !== 1'b1 || bCounter !== '0 || bDone !== 1'b0)
      begin errors++; $display("[TB] FAIL singleRun: busy=%b counter=%0d done=%b required 1 0 0", bBusy, bCounter, bDone); end
    stepClock();
    checks++;
    if (bDone !== 1'b1 || bCounter !== '0)
      begin errors++; $display("[TB] FAIL singleDone: done=%b counter=%0d required 1 0", bDone, bCounter); end
    stepClock();
    checks++;
    if (bDone !== 1'b0 || bBusy !== 1'b0)
      begin errors++; $display("[TB] FAIL singleAfter: done=%b busy=%b required 0 0", bDone, bBusy); end
  endtask

  task automatic test_overflow();
    int accepted;
    logic expReady;
    logic [DW-1:0] w;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      w = DW'($urandom);
      bValid = 1; bLast = 0; bData = w;
      expReady = (accepted < (1 << AWB));
      checks++;
      if (bReady !== expReady) begin errors++; $display("[TB] FAIL ovfReady k=%0d: got %b required %b", k, bReady, expReady); end
      stepClock();
      checks++;
      if (expReady) begin
        if (bWe !== 1'b1 || bWaddr !== AWB'(accepted) || bWdata !== w) begin
          errors++;
          $display("[TB] FAIL ovfWrite k=%0d: we=%b addr=%0d data=%h required 1 %0d %h", k, bWe, bWaddr, bWdata, accepted, w);
        end
        accepted++;
      end else if (bWe !== 1'b0) begin
        errors++; $display("[TB] FAIL ovfNoWrite k=%0d: we=%b required 0", k, bWe);
      end
      checks++;
      if (bOvf !== (k >= (1 << AWB))) begin errors++; $display("[TB] FAIL ovfFlag k=%0d: got %b required %b", k, bOvf, (k >= (1 << AWB))); end
    end
    bValid = 0;
    checks++;
    if (bLen !== 3'd4 || bBusy !== 1'b0) begin errors++; $display("[TB] FAIL ovfLen: len=%0d busy=%b required 4 0", bLen, bBusy); end
    stepClock();
    checks++;
    if (bReady !== 1'b1 || bOvf !== 1'b1) begin errors++; $display("[TB] FAIL ovfRecover: ready=%b ovf=%b required 1 1", bReady, bOvf); end
    w = DW'($urandom);
    bValid = 1; bData = w; bLast = 1;
    stepClock();
    bValid = 0; bLast = 0;
    checks++;
    if (bWaddr !== '0 || bWdata !== w || bLen !== 3'd1 || bOvf !== 1'b1)
      begin errors++; $display("[TB] FAIL ovfReload: addr=%0d data=%h len=%0d ovf=%b required 0 %h 1 1", bWaddr, bWdata, bLen, bOvf, w); end
  endtask

  task automatic test_load_and_run();
    words = '{18'h00011, 18'h00022, 18'h00033, 18'h3FFFF};
    loadA("planLoad");
    runA(4);
  endtask

  task automatic test_random_loads();
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
      loadA("randLoad");
      if (r != 1) runA(n);
    end
  endtask

  task automatic test_start_with_load();
    aStart = 1; aValid = 1; aData = 18'h0ABCD; aLast = 0;
    stepClock();
    aStart = 0;
    checks++;
    if (aWe !== 1'b1 || aWaddr !== '0 || aBusy !== 1'b1)
      begin errors++; $display("[TB] FAIL startVsLoad: we=%b addr=%0d busy=%b required 1 0 1", aWe, aWaddr, aBusy); end
    aData = 18'h1234; aLast = 1;
    stepClock();
    aValid = 0; aLast = 0;
    stepClock();
    checks++;
    if (aBusy !== 1'b0 || aLen !== 11'd2 || aDone !== 1'b0)
      begin errors++; $display("[TB] FAIL startDropped: busy=%b len=%0d done=%b required 0 2 0", aBusy, aLen, aDone); end
  endtask

  task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
    words = '{18'h3FFFF, 18'h00002};
    loadA("checksumLoad");
    checks++;
    if (aChecksum !== 18'h00001) begin errors++; $display("[TB] FAIL checksumWrap: got %h required 00001", aChecksum); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int waited;
    words = '{18'h00011, 18'h00022, 18'h00033, 18'h3FFFF};
    loadA("preResetLoad");
    aStart = 1;
    stepClock();
    aStart = 0;
    waited = 0;
    while (aCounter !== AWA'(2) && waited < 40) begin
      stepClock();
      waited++;
    end
    checks++;
    if (aCounter !== AWA'(2)) begin errors++; $display("[TB] FAIL reachCounter2: counter=%0d required 2", aCounter); end
    rstn = 1'b0;
    stepClock();
    checks++;
    if ({aReady, aWe, aBusy, aDone, aOvf, aWaddr, aWdata, aCounter, aLen} !== '0)
      begin errors++; $display("[TB] FAIL midRunReset: outputs=%h required all zero",
        {aReady, aWe, aBusy, aDone, aOvf, aWaddr, aWdata, aCounter, aLen}); end
    rstn = 1'b1;
    for (int k = 0; k < 15; k++) begin
      stepClock();
      checks++;
      if (aDone !== 1'b0 || aBusy !== 1'b0) begin errors++; $display("[TB] FAIL noDoneAfterReset k=%0d: done=%b busy=%b required 0 0", k, aDone, aBusy); end
    end
  endtask

  // Test sequence
  initial begin
    @(negedge clk);
    test_reset();
    test_start_empty();
    test_overflow();
    test_load_and_run();
    test_random_loads();
    test_start_with_load();
    test_checksum();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stalled sequence
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
